// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: I-side and D-side cache request ports plus the shared RAM port.
// The slave modport is the arbiter's view; master is the surrounding caches and RAM model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              startReqI;
    logic [ADDR_W-1:0] inAddrI;
    logic [DATA_W-1:0] inDataI;
    logic              isRdI;
    logic              reqFinishI;
    logic [DATA_W-1:0] outDataI;

    logic              startReqD;
    logic [ADDR_W-1:0] inAddrD;
    logic [DATA_W-1:0] inDataD;
    logic              isRdD;
    logic              reqFinishD;
    logic [DATA_W-1:0] outDataD;

    logic              memEn;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic              memIsRd;
    logic              memDone;
    logic [DATA_W-1:0] memResult;

    logic              busyM;
    logic              ownerD;

    modport slave (
        input  startReqI, inAddrI, inDataI, isRdI,
        output reqFinishI, outDataI,
        input  startReqD, inAddrD, inDataD, isRdD,
        output reqFinishD, outDataD,
        output memEn, memAddr, memData, memIsRd,
        input  memDone, memResult,
        output busyM, ownerD
    );

    modport master (
        output startReqI, inAddrI, inDataI, isRdI,
        input  reqFinishI, outDataI,
        output startReqD, inAddrD, inDataD, isRdD,
        input  reqFinishD, outDataD,
        input  memEn, memAddr, memData, memIsRd,
        output memDone, memResult,
        input  busyM, ownerD
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter serialising I-cache and D-cache line transfers onto one RAM port,
// one outstanding transaction at a time, round-robin (or I-first) on ties.
//
// state  | meaning
// S_IDLE | no transaction; evaluate requests and grant one
// S_BUSY | RAM request held on the latched address/data until memDone
// S_DONE | one-cycle reqFinish pulse to the owner, then back to idle
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 64,
    parameter int FIXED_PRIO = 0
) (
    input logic          clk,
    input logic          rstn,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_was_d_q, last_was_d_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              is_rd_q, is_rd_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic gnt_to_d;
    logic mem_en, fin_i, fin_d, busy;

    // On a tie the side that was not served last wins, unless I has fixed priority.
    assign gnt_to_d = (bus.startReqI && bus.startReqD)
                    ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_was_d_q)
                    : bus.startReqD;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q      <= S_IDLE;
            last_was_d_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            is_rd_q      <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_was_d_q <= last_was_d_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            is_rd_q      <= is_rd_d;
            result_q     <= result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_was_d_d = last_was_d_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        data_d       = data_q;
        is_rd_d      = is_rd_q;
        result_d     = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.startReqI || bus.startReqD) begin
                    owner_d = gnt_to_d;
                    addr_d  = gnt_to_d ? bus.inAddrD : bus.inAddrI;
                    data_d  = gnt_to_d ? bus.inDataD : bus.inDataI;
                    is_rd_d = gnt_to_d ? bus.isRdD   : bus.isRdI;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.memDone) begin
                    result_d = bus.memResult;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                last_was_d_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en = (state_q == S_BUSY);
        fin_i  = (state_q == S_DONE) && !owner_q;
        fin_d  = (state_q == S_DONE) && owner_q;
        busy   = (state_q != S_IDLE);
    end

    assign bus.memEn      = mem_en;
    assign bus.memAddr    = addr_q;
    assign bus.memData    = data_q;
    assign bus.memIsRd    = is_rd_q;
    assign bus.reqFinishI = fin_i;
    assign bus.reqFinishD = fin_d;
    assign bus.outDataI   = result_q;
    assign bus.outDataD   = result_q;
    assign bus.busyM      = busy;
    assign bus.ownerD     = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random contention, every cycle checked
// against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rstn;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: 0 free, 1 RAM transfer in flight, 2 finish cycle
    int            m_phase;
    bit            m_last, m_owner, m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_result;

    int            rem_i, rem_d, cool_i, cool_d;
    int            ram_lat, ram_cnt;
    bit            spurious, ram_fix_en;
    logic [DW-1:0] ram_fix_val;

    int            men_cycles, fin_i_cnt, fin_d_cnt;
    bit            prev_men;
    bit            grants[$];
    logic [AW-1:0] gaddr[$];
    bit            grd[$];
    logic [DW-1:0] last_out_i, last_out_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_last   = 1'b1;
        m_owner  = 1'b0;
        m_rd     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_result = '0;
    endtask

    task automatic clr_obs();
        men_cycles = 0;
        fin_i_cnt  = 0;
        fin_d_cnt  = 0;
        grants.delete();
        gaddr.delete();
        grd.delete();
    endtask

    task automatic check_outputs();
        chk("memEn",      64'(bus.memEn),      64'(m_phase == 1));
        chk("busyM",      64'(bus.busyM),      64'(m_phase != 0));
        chk("reqFinishI", 64'(bus.reqFinishI), 64'(m_phase == 2 && !m_owner));
        chk("reqFinishD", 64'(bus.reqFinishD), 64'(m_phase == 2 && m_owner));
        chk("ownerD",     64'(bus.ownerD),     64'(m_owner));
        chk("memAddr",    64'(bus.memAddr),    64'(m_addr));
        chk("memData",    bus.memData,         m_data);
        chk("memIsRd",    64'(bus.memIsRd),    64'(m_rd));
        chk("outDataI",   bus.outDataI,        m_result);
        chk("outDataD",   bus.outDataD,        m_result);
    endtask

    task automatic tick();
        bit            s_rst, s_ri, s_rq_d, s_wi, s_wd, s_done;
        logic [AW-1:0] s_ai, s_ad;
        logic [DW-1:0] s_di, s_dd, s_res;
        s_rst  = rstn;
        s_ri   = bus.startReqI;  s_ai = bus.inAddrI;  s_di = bus.inDataI;  s_wi = bus.isRdI;
        s_rq_d = bus.startReqD;  s_ad = bus.inAddrD;  s_dd = bus.inDataD;  s_wd = bus.isRdD;
        s_done = bus.memDone;    s_res = bus.memResult;
        @(posedge clk);
        if (s_rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (s_ri || s_rq_d) begin
                    m_owner = (s_ri && s_rq_d) ? !m_last : s_rq_d;
                    if (m_owner) begin m_addr = s_ad; m_data = s_dd; m_rd = s_wd; end
                    else         begin m_addr = s_ai; m_data = s_di; m_rd = s_wi; end
                    m_phase = 1;
                end
                1: if (s_done) begin m_result = s_res; m_phase = 2; end
                default: begin m_last = m_owner; m_phase = 0; end
            endcase
        end
        @(negedge clk);
        check_outputs();

        if (bus.memEn) men_cycles++;
        if (bus.memEn && !prev_men) begin
            grants.push_back(bus.ownerD);
            gaddr.push_back(bus.memAddr);
            grd.push_back(bus.memIsRd);
        end
        prev_men = bus.memEn;
        if (bus.reqFinishI) begin fin_i_cnt++; last_out_i = bus.outDataI; end
        if (bus.reqFinishD) begin fin_d_cnt++; last_out_d = bus.outDataD; end

        // RAM model
        if (bus.memEn) begin
            ram_cnt++;
            bus.memDone = (ram_cnt == ram_lat);
        end else begin
            ram_cnt = 0;
            bus.memDone = spurious;
        end
        bus.memResult = ram_fix_en ? ram_fix_val : {$urandom, $urandom};

        // requesters: drop after finish, stay low through the following idle cycle
        if (bus.reqFinishI) begin
            bus.startReqI = 1'b0; if (rem_i > 0) rem_i--; cool_i = 1;
        end else if (cool_i > 0) begin
            cool_i--;
        end else if (rem_i > 0 && !bus.startReqI) begin
            bus.startReqI = 1'b1; bus.inAddrI = 16'($urandom);
            bus.inDataI = {$urandom, $urandom}; bus.isRdI = 1'($urandom);
        end
        if (bus.reqFinishD) begin
            bus.startReqD = 1'b0; if (rem_d > 0) rem_d--; cool_d = 1;
        end else if (cool_d > 0) begin
            cool_d--;
        end else if (rem_d > 0 && !bus.startReqD) begin
            bus.startReqD = 1'b1; bus.inAddrD = 16'($urandom);
            bus.inDataD = {$urandom, $urandom}; bus.isRdD = 1'($urandom);
        end
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            tick();
            n++;
            ok = (rem_i == 0 && rem_d == 0 && m_phase == 0 && !bus.startReqI && !bus.startReqD);
        end
        chk({tag, "_completes"}, 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        model_reset();
        bus.startReqI = 1'b0; bus.startReqD = 1'b0;
        rem_i = 0; rem_d = 0; cool_i = 0; cool_d = 0;
        tick();
        tick();
        rstn = 1'b0;
    endtask

    initial begin
        bus.startReqI = 1'b0; bus.inAddrI = '0; bus.inDataI = '0; bus.isRdI = 1'b0;
        bus.startReqD = 1'b0; bus.inAddrD = '0; bus.inDataD = '0; bus.isRdD = 1'b0;
        bus.memDone = 1'b0; bus.memResult = '0;
        ram_lat = 1; ram_cnt = 0; spurious = 1'b0; ram_fix_en = 1'b0; ram_fix_val = '0;
        prev_men = 1'b0; last_out_i = '0; last_out_d = '0;
        clr_obs();
        do_reset();

        // single I read
        clr_obs();
        ram_fix_en = 1'b1; ram_fix_val = 64'h1111_2222_3333_4444; ram_lat = 1;
        bus.startReqI = 1'b1; bus.inAddrI = 16'h0040; bus.isRdI = 1'b1; bus.inDataI = '0; rem_i = 1;
        wait_done(20, "t1");
        chk("t1_grants",  64'(grants.size()), 64'd1);
        chk("t1_memAddr", 64'(gaddr[0]), 64'h0040);
        chk("t1_memIsRd", 64'(grd[0]), 64'd1);
        chk("t1_outData", last_out_i, 64'h1111_2222_3333_4444);
        chk("t1_finI",    64'(fin_i_cnt), 64'd1);
        chk("t1_finD",    64'(fin_d_cnt), 64'd0);
        ram_fix_en = 1'b0;

        // simultaneous requests out of reset
        do_reset();
        clr_obs();
        bus.startReqI = 1'b1; bus.inAddrI = 16'h1234; bus.isRdI = 1'b1; rem_i = 1;
        bus.startReqD = 1'b1; bus.inAddrD = 16'h5678; bus.isRdD = 1'b1; rem_d = 1;
        wait_done(30, "t2");
        chk("t2_grants", 64'(grants.size()), 64'd2);
        chk("t2_first",  64'(grants[0]), 64'd0);
        chk("t2_addr0",  64'(gaddr[0]), 64'h1234);
        chk("t2_second", 64'(grants[1]), 64'd1);
        chk("t2_addr1",  64'(gaddr[1]), 64'h5678);
        chk("t2_finI",   64'(fin_i_cnt), 64'd1);
        chk("t2_finD",   64'(fin_d_cnt), 64'd1);

        // sustained contention
        clr_obs();
        ram_lat = 1;
        bus.startReqI = 1'b1; bus.inAddrI = 16'($urandom); rem_i = 3;
        bus.startReqD = 1'b1; bus.inAddrD = 16'($urandom); rem_d = 3;
        wait_done(60, "t3");
        chk("t3_grants", 64'(grants.size()), 64'd6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("t3_order%0d", k), 64'(grants[k]), 64'(k % 2));

        // after a lone I transfer, a tie goes to D
        clr_obs();
        bus.startReqI = 1'b1; rem_i = 1;
        wait_done(20, "t3b_single");
        bus.startReqI = 1'b1; rem_i = 1;
        bus.startReqD = 1'b1; rem_d = 1;
        wait_done(30, "t3b_tie");
        chk("t3b_grants", 64'(grants.size()), 64'd3);
        chk("t3b_tie_first", 64'(grants[1]), 64'd1);

        // D write with a long RAM stall and a moving input address
        clr_obs();
        ram_lat = 10;
        bus.startReqD = 1'b1; bus.isRdD = 1'b0; bus.inAddrD = 16'h0100;
        bus.inDataD = 64'hDEAD_BEEF_0000_0001; rem_d = 1;
        repeat (4) tick();
        bus.inAddrD = 16'h0200;
        wait_done(40, "t4");
        chk("t4_memEn_cycles", 64'(men_cycles), 64'd10);
        chk("t4_memAddr",      64'(gaddr[0]), 64'h0100);
        chk("t4_memIsRd",      64'(grd[0]), 64'd0);
        chk("t4_finD",         64'(fin_d_cnt), 64'd1);
        chk("t4_finI",         64'(fin_i_cnt), 64'd0);

        // reset while the RAM request is up
        clr_obs();
        ram_lat = 50;
        bus.startReqI = 1'b1; bus.inAddrI = 16'h0abc; bus.isRdI = 1'b1; rem_i = 1;
        repeat (3) tick();
        chk("t5_busy_before", 64'(bus.memEn), 64'd1);
        rstn = 1'b1;
        #1;
        model_reset();
        chk("t5_memEn_now", 64'(bus.memEn), 64'd0);
        chk("t5_busyM_now", 64'(bus.busyM), 64'd0);
        bus.startReqI = 1'b0; rem_i = 0; cool_i = 0;
        tick();
        tick();
        rstn = 1'b0;
        chk("t5_no_finish", 64'(fin_i_cnt + fin_d_cnt), 64'd0);
        clr_obs();
        ram_lat = 2;
        bus.startReqI = 1'b1; bus.inAddrI = 16'h0ccc; rem_i = 1;
        wait_done(20, "t5_after");
        chk("t5_finI", 64'(fin_i_cnt), 64'd1);
        chk("t5_addr", 64'(gaddr[0]), 64'h0ccc);

        // memDone while idle
        clr_obs();
        last_out_i = m_result;
        spurious = 1'b1;
        repeat (4) tick();
        spurious = 1'b0;
        tick();
        chk("t6_result_kept", bus.outDataI, last_out_i);
        chk("t6_no_finish",   64'(fin_i_cnt + fin_d_cnt), 64'd0);
        chk("t6_no_grant",    64'(grants.size()), 64'd0);

        // random contention with random latencies and idle-time memDone noise
        for (int r = 0; r < 6; r++) begin
            int ni, nd;
            clr_obs();
            ni = $urandom_range(8, 1);
            nd = $urandom_range(8, 1);
            ram_lat = $urandom_range(5, 1);
            spurious = 1'(r % 2);
            rem_i = ni; rem_d = nd;
            wait_done(400, $sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_finI", r), 64'(fin_i_cnt), 64'(ni));
            chk($sformatf("rnd%0d_finD", r), 64'(fin_d_cnt), 64'(nd));
        end
        spurious = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
